// File: rtl/adsr_gain.sv
// Gate-driven ADSR envelope applied to the oscillator sample stream, producing saturated
// signed PCM through a two-stage multiply/shift pipeline. The envelope advances once per sample.
module adsr_gain #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned ENV_W    = 16,
  parameter int unsigned IN_SHIFT = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         in_sample_i,
  input  logic                    in_valid_i,
  input  logic                    gate_i,
  input  logic [ENV_W-1:0]        attack_step_i,
  input  logic [ENV_W-1:0]        decay_step_i,
  input  logic [ENV_W-1:0]        sustain_level_i,
  input  logic [ENV_W-1:0]        release_step_i,
  output logic signed [OUT_W-1:0] out_sample_o,
  output logic                    out_valid_o,
  output logic [ENV_W-1:0]        env_level_o,
  output logic [2:0]              env_state_o
);

  localparam int unsigned ProdW = IN_W + ENV_W + 1;
  localparam int unsigned Shift = ENV_W + IN_SHIFT - OUT_W + 1;

  localparam logic [ENV_W-1:0] EnvMax = {ENV_W{1'b1}};
  localparam logic signed [ProdW-1:0] SatHi =
      {{(ProdW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ProdW-1:0] SatLo =
      {{(ProdW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;

  // Envelope arithmetic in ENV_W+1 bits so overflow/borrow is visible and clamped.
  logic [ENV_W:0]   att_sum, dec_diff, rel_diff;
  logic [ENV_W-1:0] att_env;
  logic             att_full, dec_to_sus, rel_to_zero;

  always_comb begin
    att_sum  = {1'b0, env_q} + {1'b0, attack_step_i};
    dec_diff = {1'b0, env_q} - {1'b0, decay_step_i};
    rel_diff = {1'b0, env_q} - {1'b0, release_step_i};

    att_full = (attack_step_i == '0) || (att_sum >= {1'b0, EnvMax});
    att_env  = att_full ? EnvMax : att_sum[ENV_W-1:0];

    dec_to_sus = (decay_step_i == '0) || (sustain_level_i >= env_q) || dec_diff[ENV_W] ||
                 (dec_diff[ENV_W-1:0] <= sustain_level_i);

    rel_to_zero = (release_step_i == '0) || rel_diff[ENV_W] || (rel_diff[ENV_W-1:0] == '0);
  end

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (in_valid_i) begin
      case (state_q)
        StIdle: begin
          if (gate_i) begin
            env_d   = att_env;
            state_d = att_full ? StDecay : StAttack;
          end else begin
            env_d = '0;
          end
        end
        StAttack: begin
          if (!gate_i) begin
            state_d = StRelease;
          end else begin
            env_d   = att_env;
            state_d = att_full ? StDecay : StAttack;
          end
        end
        StDecay: begin
          if (!gate_i) begin
            state_d = StRelease;
          end else if (dec_to_sus) begin
            env_d   = sustain_level_i;
            state_d = StSustain;
          end else begin
            env_d = dec_diff[ENV_W-1:0];
          end
        end
        StSustain: begin
          if (!gate_i) begin
            state_d = StRelease;
          end else begin
            env_d = sustain_level_i;
          end
        end
        StRelease: begin
          // Retrigger starts from the current level, not from zero.
          if (gate_i) begin
            env_d   = att_env;
            state_d = att_full ? StDecay : StAttack;
          end else if (rel_to_zero) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = rel_diff[ENV_W-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Stage 1: signed sample times zero-extended envelope (pre-update level).
  logic signed [ProdW-1:0] in_ext, env_ext, prod_d, prod_q;
  logic                    vld1_q;

  always_comb begin
    in_ext  = {{(ProdW - IN_W){in_sample_i[IN_W-1]}}, in_sample_i};
    env_ext = {{(ProdW - ENV_W){1'b0}}, env_q};
    prod_d  = in_ext * env_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= in_valid_i;
      if (in_valid_i) begin
        prod_q <= prod_d;
      end
    end
  end

  // Stage 2: arithmetic (flooring) shift, then saturate to the PCM range.
  logic signed [ProdW-1:0] shifted;
  logic signed [OUT_W-1:0] sat;
  logic signed [OUT_W-1:0] out_q;
  logic                    out_valid_q;

  always_comb begin
    shifted = prod_q >>> Shift;
    if (shifted > SatHi) begin
      sat = SatHi[OUT_W-1:0];
    end else if (shifted < SatLo) begin
      sat = SatLo[OUT_W-1:0];
    end else begin
      sat = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld1_q;
      if (vld1_q) begin
        out_q <= sat;
      end
    end
  end

  assign out_sample_o = out_q;
  assign out_valid_o  = out_valid_q;
  assign env_level_o  = env_q;
  assign env_state_o  = state_q;

endmodule

// File: tb/tb_adsr_gain.sv
// Directed bench for adsr_gain: table of envelope ticks with hand-computed env/state/PCM,
// plus sequences for reset, back-to-back streaming and latency.
module tb_adsr_gain;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        in_sample = '0;
  logic               in_valid = 1'b0;
  logic               gate = 1'b0;
  logic [15:0]        attack_step = '0;
  logic [15:0]        decay_step = '0;
  logic [15:0]        sustain_level = '0;
  logic [15:0]        release_step = '0;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic [15:0]        env_level;
  logic [2:0]         env_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic signed [31:0] P20 = 32'sd1048576;
  localparam logic signed [31:0] N20 = -32'sd1048576;
  localparam logic signed [31:0] P24 = 32'sd16777216;
  localparam logic signed [31:0] N24 = -32'sd16777216;

  adsr_gain dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_sample_i     (in_sample),
    .in_valid_i      (in_valid),
    .gate_i          (gate),
    .attack_step_i   (attack_step),
    .decay_step_i    (decay_step),
    .sustain_level_i (sustain_level),
    .release_step_i  (release_step),
    .out_sample_o    (out_sample),
    .out_valid_o     (out_valid),
    .env_level_o     (env_level),
    .env_state_o     (env_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               gate;
    logic [15:0]        att;
    logic [15:0]        dec;
    logic [15:0]        sus;
    logic [15:0]        rel;
    logic signed [31:0] smp;
    logic [15:0]        env;
    logic [2:0]         st;
    logic signed [15:0] pcm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic g, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] s, input logic [15:0] r, input logic signed [31:0] x,
                     input logic [15:0] e, input logic [2:0] st, input logic signed [15:0] p);
    vec_t v;
    v.gate = g; v.att = a; v.dec = d; v.sus = s; v.rel = r;
    v.smp = x; v.env = e; v.st = st; v.pcm = p;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Attack 0x4000 up to full scale, decay 0x1000 down to sustain 0x8000.
    // Sample +2^20 gives PCM = (envelope before the tick) >> 1.
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h4000, 3'd1, 16'sd0);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h8000, 3'd1, 16'sd8192);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hC000, 3'd1, 16'sd16384);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hFFFF, 3'd2, 16'sd24576);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hEFFF, 3'd2, 16'sd32767);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hDFFF, 3'd2, 16'sd30719);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hCFFF, 3'd2, 16'sd28671);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hBFFF, 3'd2, 16'sd26623);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hAFFF, 3'd2, 16'sd24575);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h9FFF, 3'd2, 16'sd22527);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h8FFF, 3'd2, 16'sd20479);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h8000, 3'd3, 16'sd18431);
    add(1, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h8000, 3'd3, 16'sd16384);
    // Release 0x3000, retrigger with attack 0x1000, then release to zero.
    add(0, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h8000, 3'd4, 16'sd16384);
    add(0, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h5000, 3'd4, 16'sd16384);
    add(0, 16'h4000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h2000, 3'd4, 16'sd10240);
    add(1, 16'h1000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h3000, 3'd1, 16'sd4096);
    add(0, 16'h1000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h3000, 3'd4, 16'sd6144);
    add(0, 16'h1000, 16'h1000, 16'h8000, 16'h3000, P20, 16'h0000, 3'd0, 16'sd6144);
    // Zero steps: instant attack, instant decay, instant release.
    add(1, 16'h0000, 16'h1000, 16'h8000, 16'h3000, P20, 16'hFFFF, 3'd2, 16'sd0);
    add(1, 16'h0000, 16'h0000, 16'h8000, 16'h3000, P20, 16'h8000, 3'd3, 16'sd32767);
    add(0, 16'h0000, 16'h0000, 16'h8000, 16'h0000, P20, 16'h8000, 3'd4, 16'sd16384);
    add(0, 16'h0000, 16'h0000, 16'h8000, 16'h0000, P20, 16'h0000, 3'd0, 16'sd16384);
    // Unity sustain: scaling, saturation and flooring.
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, P20, 16'hFFFF, 3'd2, 16'sd0);
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, P20, 16'hFFFF, 3'd3, 16'sd32767);
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, N20, 16'hFFFF, 3'd3, -16'sd32768);
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, P24, 16'hFFFF, 3'd3, 16'sd32767);
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, N24, 16'hFFFF, 3'd3, -16'sd32768);
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, 32'sd524288, 16'hFFFF, 3'd3, 16'sd16383);
    add(1, 16'h0000, 16'h1000, 16'hFFFF, 16'h3000, -32'sd3, 16'hFFFF, 3'd3, -16'sd1);
    // Sustain follows live changes of sustain_level.
    add(1, 16'h0000, 16'h1000, 16'h1234, 16'h3000, P20, 16'h1234, 3'd3, 16'sd32767);
    add(1, 16'h0000, 16'h1000, 16'h1234, 16'h3000, P20, 16'h1234, 3'd3, 16'sd2330);

    // Reset state while held.
    #12;
    chk("reset env_level", int'(env_level), 0);
    chk("reset env_state", int'(env_state), 0);
    chk("reset out_sample", int'(out_sample), 0);
    chk("reset out_valid", int'(out_valid), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Tick with gate low from IDLE: stays idle at zero.
    gate = 1'b0; in_sample = P20; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("idle tick state", int'(env_state), 0);
    chk("idle tick env", int'(env_level), 0);
    cyc();
    chk("idle tick out_valid", int'(out_valid), 1);
    chk("idle tick out_sample", int'(out_sample), 0);
    cyc(); cyc();

    for (int i = 0; i < vecs.size(); i++) begin
      gate = vecs[i].gate;
      attack_step = vecs[i].att;
      decay_step = vecs[i].dec;
      sustain_level = vecs[i].sus;
      release_step = vecs[i].rel;
      in_sample = vecs[i].smp;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk($sformatf("row%0d env", i), int'(env_level), int'(vecs[i].env));
      chk($sformatf("row%0d state", i), int'(env_state), int'(vecs[i].st));
      chk($sformatf("row%0d early out_valid", i), int'(out_valid), 0);
      cyc();
      chk($sformatf("row%0d out_valid", i), int'(out_valid), 1);
      chk($sformatf("row%0d out_sample", i), int'(out_sample), int'(vecs[i].pcm));
      cyc();
      chk($sformatf("row%0d out_valid drop", i), int'(out_valid), 0);
      chk($sformatf("row%0d out_sample hold", i), int'(out_sample), int'(vecs[i].pcm));
      cyc();
    end

    // Back-to-back: return to unity sustain, then 8 consecutive alternating samples.
    gate = 1'b1; sustain_level = 16'hFFFF; in_sample = '0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("b2b setup env", int'(env_level), 16'hFFFF);
    cyc(); cyc();
    begin
      int nvld;
      nvld = 0;
      for (int k = 0; k < 11; k++) begin
        in_valid = (k < 8);
        in_sample = (k % 2 == 0) ? P20 : N20;
        cyc();
        if (out_valid) nvld++;
        chk($sformatf("b2b out_valid k%0d", k), int'(out_valid), (k >= 1 && k <= 8) ? 1 : 0);
        if (k >= 1 && k <= 8)
          chk($sformatf("b2b out_sample k%0d", k), int'(out_sample),
              ((k - 1) % 2 == 0) ? 32767 : -32768);
      end
      in_valid = 1'b0;
      chk("b2b strobe count", nvld, 8);
    end

    // Reset mid-note with in_valid toggling: immediate clear, no strobe afterwards.
    gate = 1'b1; attack_step = 16'h4000; in_sample = P20;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k % 2 == 0);
      cyc();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset env_level", int'(env_level), 0);
    chk("midreset env_state", int'(env_state), 0);
    chk("midreset out_sample", int'(out_sample), 0);
    chk("midreset out_valid", int'(out_valid), 0);
    for (int k = 0; k < 4; k++) begin
      in_valid = (k % 2 == 0);
      cyc();
      chk($sformatf("in reset out_valid k%0d", k), int'(out_valid), 0);
      chk($sformatf("in reset env k%0d", k), int'(env_level), 0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("post reset out_valid a", int'(out_valid), 0);
    cyc();
    chk("post reset out_valid b", int'(out_valid), 0);
    chk("post reset state", int'(env_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
